// File: rtl/ibuf_fifo_pkg.sv
// Shared router constants: output direction bit positions and default widths
// used by the input buffer and its storage.
package ibuf_fifo_pkg;

  localparam int DIR_N = 0;
  localparam int DIR_S = 1;
  localparam int DIR_E = 2;
  localparam int DIR_W = 3;
  localparam int DIR_B = 4;

  localparam int NPORT_DFLT   = 5;
  localparam int ROUTE_MASK_W = NPORT_DFLT;
  localparam int PKT_W        = 16;

  typedef logic [ROUTE_MASK_W-1:0] route_mask_t;

endpackage

// File: rtl/ibuf_fifo_mem.sv
// Circular packet store for the input buffer: DEPTH entries of {route, payload},
// explicit pointer wrap (any DEPTH >= 2), occupancy and registered full flag.
module ibuf_fifo_mem
  import ibuf_fifo_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = ROUTE_MASK_W + PKT_W,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] next_data,
  output logic [CNT_W-1:0]  occ,
  output logic              full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_nxt_s;
  logic [CNT_W-1:0]  occ_r;
  logic [CNT_W-1:0]  occ_nxt_s;
  logic              full_r;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] res;
    if (ptr == PTR_W'(DEPTH - 1)) begin
      res = {PTR_W{1'b0}};
    end else begin
      res = ptr + PTR_W'(1);
    end
    return res;
  endfunction

  // The entry behind the head is what gets promoted when the head retires.
  assign rd_nxt_s  = wrap_inc(rd_ptr_r);
  assign next_data = mem_r[rd_nxt_s];
  assign occ       = occ_r;
  assign full      = full_r;

  // Next occupancy: push and pop in the same cycle cancel out.
  always_comb begin
    occ_nxt_s = occ_r;
    case ({wr_en, rd_en})
      2'b10:   occ_nxt_s = occ_r + CNT_W'(1);
      2'b01:   occ_nxt_s = occ_r - CNT_W'(1);
      default: occ_nxt_s = occ_r;
    endcase
  end

  // Pointer, occupancy and full-flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      occ_r    <= {CNT_W{1'b0}};
      full_r   <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_r <= wrap_inc(wr_ptr_r);
      end
      if (rd_en) begin
        rd_ptr_r <= rd_nxt_s;
      end
      occ_r  <= occ_nxt_s;
      full_r <= (occ_nxt_s == CNT_W'(DEPTH));
    end
  end

  // Entry storage; cleared on reset so no stale route can ever surface.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_en) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

endmodule

// File: rtl/ibuf_fifo.sv
// Multi-entry router input buffer: queues packets in order and presents the
// head's outstanding route bits, retiring each bit on grant with output ready.
module ibuf_fifo
  import ibuf_fifo_pkg::*;
#(
  parameter int PYLD_W = PKT_W,
  parameter int NPORT  = NPORT_DFLT,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ibuf_vld,
  output logic              ibuf_rdy,
  input  logic [NPORT-1:0]  route_req,
  input  logic [PYLD_W-1:0] payload_i,
  output logic [NPORT-1:0]  arb_req,
  input  logic [NPORT-1:0]  arb_gnt,
  input  logic [NPORT-1:0]  obuf_rdy,
  output logic [PYLD_W-1:0] payload_o,
  output logic [CNT_W-1:0]  occ,
  output logic              drop
);

  localparam int ENT_W = NPORT + PYLD_W;

  logic              push_s;
  logic              keep_s;
  logic              pop_s;
  logic              head_vld_s;
  logic              full_s;
  logic [NPORT-1:0]  pend_r;
  logic [NPORT-1:0]  pend_nxt_s;
  logic [NPORT-1:0]  clr_s;
  logic [NPORT-1:0]  rem_s;
  logic [PYLD_W-1:0] pyld_r;
  logic [PYLD_W-1:0] pyld_nxt_s;
  logic [ENT_W-1:0]  next_ent_s;
  logic [CNT_W-1:0]  occ_s;
  logic              drop_r;

  // A held packet always has at least one pending bit, so a nonzero mask
  // doubles as the head-valid flag.
  assign head_vld_s = |pend_r;
  assign push_s     = ibuf_vld & ~full_s;
  assign keep_s     = push_s & (|route_req);
  assign clr_s      = arb_gnt & obuf_rdy & pend_r;
  assign rem_s      = pend_r & ~clr_s;
  assign pop_s      = head_vld_s & ~(|rem_s);

  ibuf_fifo_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (ENT_W),
    .CNT_W  (CNT_W)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (keep_s),
    .wr_data   ({route_req, payload_i}),
    .rd_en     (pop_s),
    .next_data (next_ent_s),
    .occ       (occ_s),
    .full      (full_s)
  );

  // Head selection: promote the stored successor, else bypass the incoming
  // packet, else go idle while keeping the last payload visible.
  always_comb begin
    pend_nxt_s = rem_s;
    pyld_nxt_s = pyld_r;
    if (pop_s) begin
      if (occ_s > CNT_W'(1)) begin
        pend_nxt_s = next_ent_s[ENT_W-1 -: NPORT];
        pyld_nxt_s = next_ent_s[PYLD_W-1:0];
      end else if (keep_s) begin
        pend_nxt_s = route_req;
        pyld_nxt_s = payload_i;
      end else begin
        pend_nxt_s = {NPORT{1'b0}};
      end
    end else if (!head_vld_s && keep_s) begin
      pend_nxt_s = route_req;
      pyld_nxt_s = payload_i;
    end else begin
      pend_nxt_s = rem_s;
    end
  end

  // Head pending mask, head payload and drop pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r <= {NPORT{1'b0}};
      pyld_r <= {PYLD_W{1'b0}};
      drop_r <= 1'b0;
    end else begin
      pend_r <= pend_nxt_s;
      pyld_r <= pyld_nxt_s;
      drop_r <= push_s & ~(|route_req);
    end
  end

  assign ibuf_rdy  = ~full_s;
  assign arb_req   = pend_r;
  assign payload_o = pyld_r;
  assign occ       = occ_s;
  assign drop      = drop_r;

endmodule
